// File: rtl/qspi_lat_pkg.sv
// Shared definitions for the QSPI read-data latency line.
//   DefDataW / DefMaxLat : default lane width and deepest delay
//   chan_state_e         : per-channel config state (run / reload pending)
//   clamp_lat()          : limits a requested latency to the supported maximum
package qspi_lat_pkg;

  localparam int unsigned DefDataW  = 4;
  localparam int unsigned DefMaxLat = 5;

  typedef enum logic [0:0] {
    CH_RUN,
    CH_PEND
  } chan_state_e;

  function automatic int unsigned clamp_lat(input int unsigned req, input int unsigned max_lat);
    return (req > max_lat) ? max_lat : req;
  endfunction

endpackage

// File: rtl/qspi_lat_chan.sv
// One channel of the QSPI latency line: MAX_LAT-deep {valid,data} shift register, a runtime
// selectable tap, an occupancy counter and a reload FSM that only switches latency once the
// channel has drained, so no beat is ever duplicated or dropped.
// Optional feature macro: QSPI_LAT_HOLD_EN (out_data_o holds the last valid beat while idle).
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   in_data_i     : lane data          in_valid_i : lane qualifier
//   cfg_lat_i     : requested latency  cfg_load_i : request strobe
//   out_data_o    : delayed data       out_valid_o: delayed qualifier
//   lat_cur_o     : latency in force   cfg_pend_o : reload waiting for drain
//   cfg_err_o     : sticky over-range request flag
module qspi_lat_chan
  import qspi_lat_pkg::*;
#(
  parameter  int unsigned DATA_W    = DefDataW,
  parameter  int unsigned MAX_LAT   = DefMaxLat,
  parameter  int unsigned RESET_LAT = 1,
  localparam int unsigned LAT_W     = $clog2(MAX_LAT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic [LAT_W-1:0]  cfg_lat_i,
  input  logic              cfg_load_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  output logic [LAT_W-1:0]  lat_cur_o,
  output logic              cfg_pend_o,
  output logic              cfg_err_o
);

  logic [MAX_LAT-1:0] stage_v_q;
  logic [DATA_W-1:0]  stage_d_q [MAX_LAT];
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [LAT_W-1:0]   pend_lat_q, pend_lat_d;
  logic [LAT_W-1:0]   occ_q, occ_d;
  chan_state_e        state_q, state_d;
  logic               err_q, err_d;

  logic               tap_v;
  logic [DATA_W-1:0]  tap_d;
  logic [LAT_W-1:0]   req_lat;
  logic               req_over;
  logic               drained;
  logic               occ_inc, occ_dec;

  // Tap select; latency 0 bypasses the register chain entirely.
  always_comb begin
    tap_v = in_valid_i;
    tap_d = in_data_i;
    for (int k = 0; k < MAX_LAT; k++) begin
      if (lat_q == LAT_W'(k + 1)) begin
        tap_v = stage_v_q[k];
        tap_d = stage_d_q[k];
      end
    end
  end

  // Valid bits are killed once a beat has passed the tap, so a later latency increase cannot
  // re-present a beat that already left. Data keeps shifting unconditionally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_v_q <= '0;
      for (int k = 0; k < MAX_LAT; k++) stage_d_q[k] <= '0;
    end else begin
      stage_v_q[0] <= in_valid_i && (lat_q != '0);
      stage_d_q[0] <= in_data_i;
      for (int k = 1; k < MAX_LAT; k++) begin
        stage_v_q[k] <= stage_v_q[k-1] && (LAT_W'(k) < lat_q);
        stage_d_q[k] <= stage_d_q[k-1];
      end
    end
  end

  // occ counts valid beats between the input and the tap (inclusive).
  always_comb begin
    occ_inc = in_valid_i && (lat_q != '0);
    occ_dec = tap_v && (lat_q != '0);
    occ_d   = occ_q;
    if (occ_inc && !occ_dec && (occ_q != LAT_W'(MAX_LAT))) begin
      occ_d = occ_q + LAT_W'(1);
    end else if (occ_dec && !occ_inc && (occ_q != '0)) begin
      occ_d = occ_q - LAT_W'(1);
    end
  end

  assign req_lat  = LAT_W'(clamp_lat(32'(cfg_lat_i), MAX_LAT));
  assign req_over = 32'(cfg_lat_i) > MAX_LAT;
  assign drained  = (occ_q == '0) && !in_valid_i;

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    pend_lat_d = pend_lat_q;
    err_d      = err_q || (cfg_load_i && req_over);
    case (state_q)
      CH_RUN: begin
        if (cfg_load_i) begin
          if (drained) begin
            lat_d = req_lat;
          end else begin
            pend_lat_d = req_lat;
            state_d    = CH_PEND;
          end
        end
      end
      CH_PEND: begin
        if (drained) begin
          lat_d   = cfg_load_i ? req_lat : pend_lat_q;
          state_d = CH_RUN;
        end else if (cfg_load_i) begin
          pend_lat_d = req_lat;
        end
      end
      default: state_d = CH_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CH_RUN;
      lat_q      <= LAT_W'(RESET_LAT);
      pend_lat_q <= '0;
      occ_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      pend_lat_q <= pend_lat_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
    end
  end

`ifdef QSPI_LAT_HOLD_EN
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else if (tap_v) begin
      hold_q <= tap_d;
    end
  end

  assign out_data_o = tap_v ? tap_d : hold_q;
`else
  assign out_data_o = tap_d;
`endif

  assign out_valid_o = tap_v;
  assign lat_cur_o   = lat_q;
  assign cfg_pend_o  = (state_q == CH_PEND);
  assign cfg_err_o   = err_q;

endmodule

// File: rtl/qspi_latency_line.sv
// Runtime-configurable read-data latency model for the QSPI PMOD path: NUM_CH independent
// lanes, each delayed by 0..MAX_LAT clk cycles with valid tracking and safe latency reload.
// Optional feature macro: QSPI_LAT_HOLD_EN (see qspi_lat_chan).
// Ports (channel c occupies slice c of each packed vector):
//   clk, rst   : clock, asynchronous active-high reset
//   in_data    : NUM_CH*DATA_W lane data    in_valid : per-channel qualifier
//   cfg_lat    : NUM_CH*LAT_W requests      cfg_load : per-channel request strobe
//   out_data   : delayed data               out_valid: delayed qualifier
//   lat_cur    : latency in force           cfg_pend : reload waiting for drain
//   cfg_err    : sticky over-range flag
module qspi_latency_line
  import qspi_lat_pkg::*;
#(
  parameter  int unsigned DATA_W    = DefDataW,
  parameter  int unsigned MAX_LAT   = DefMaxLat,
  parameter  int unsigned NUM_CH    = 1,
  parameter  int unsigned RESET_LAT = 1,
  localparam int unsigned LAT_W     = $clog2(MAX_LAT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*LAT_W-1:0]  cfg_lat,
  input  logic [NUM_CH-1:0]        cfg_load,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*LAT_W-1:0]  lat_cur,
  output logic [NUM_CH-1:0]        cfg_pend,
  output logic [NUM_CH-1:0]        cfg_err
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    qspi_lat_chan #(
      .DATA_W   (DATA_W),
      .MAX_LAT  (MAX_LAT),
      .RESET_LAT(RESET_LAT)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_data_i  (in_data[c*DATA_W +: DATA_W]),
      .in_valid_i (in_valid[c]),
      .cfg_lat_i  (cfg_lat[c*LAT_W +: LAT_W]),
      .cfg_load_i (cfg_load[c]),
      .out_data_o (out_data[c*DATA_W +: DATA_W]),
      .out_valid_o(out_valid[c]),
      .lat_cur_o  (lat_cur[c*LAT_W +: LAT_W]),
      .cfg_pend_o (cfg_pend[c]),
      .cfg_err_o  (cfg_err[c])
    );
  end

endmodule

// File: tb/tb_qspi_latency_line.sv
// Scoreboard bench for qspi_latency_line (3 channels, 4-bit lanes, MAX_LAT 5, RESET_LAT 1).
// Stimulus pushes {expected cycle, data}; a negedge monitor pops and compares each valid beat.
module tb_qspi_latency_line;

  localparam int unsigned DW = 4;
  localparam int unsigned ML = 5;
  localparam int unsigned NC = 3;
  localparam int unsigned RL = 1;
  localparam int unsigned LW = $clog2(ML + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]    in_valid;
  logic [NC*LW-1:0] cfg_lat;
  logic [NC-1:0]    cfg_load;
  logic [NC*DW-1:0] out_data;
  logic [NC-1:0]    out_valid;
  logic [NC*LW-1:0] lat_cur;
  logic [NC-1:0]    cfg_pend;
  logic [NC-1:0]    cfg_err;

  qspi_latency_line #(
    .DATA_W   (DW),
    .MAX_LAT  (ML),
    .NUM_CH   (NC),
    .RESET_LAT(RL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .cfg_lat  (cfg_lat),
    .cfg_load (cfg_load),
    .out_data (out_data),
    .out_valid(out_valid),
    .lat_cur  (lat_cur),
    .cfg_pend (cfg_pend),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q [NC][$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    cfg_load = '0;
  endtask

  task automatic send(input int c, input logic [DW-1:0] d, input int unsigned lat);
    exp_t e;
    in_valid[c]        = 1'b1;
    in_data[c*DW +: DW] = d;
    e.cyc  = cyc + lat;
    e.data = d;
    exp_q[c].push_back(e);
  endtask

  task automatic load(input int c, input logic [LW-1:0] lat);
    cfg_load[c]         = 1'b1;
    cfg_lat[c*LW +: LW] = lat;
  endtask

  // Monitor: every valid beat must match the head of its channel queue, in data and cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        if (out_valid[c]) begin
          if (exp_q[c].size() == 0) begin
            check($sformatf("ch%0d unexpected beat", c), 32'd1, 32'd0);
          end else begin
            mon_e = exp_q[c].pop_front();
            check($sformatf("ch%0d beat data", c), 32'(out_data[c*DW +: DW]), 32'(mon_e.data));
            check($sformatf("ch%0d beat cycle", c), cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int k;
    in_valid = '0;
    in_data  = '0;
    cfg_lat  = '0;
    cfg_load = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst cfg_pend", 32'(cfg_pend), 32'd0);
    check("rst cfg_err", 32'(cfg_err), 32'd0);
    for (int c = 0; c < NC; c++) check($sformatf("rst lat_cur ch%0d", c),
                                       32'(lat_cur[c*LW +: LW]), RL);

    // 1: three beats at reset latency 1
    for (int i = 1; i <= 3; i++) begin
      send(0, DW'(i), 1);
      tick();
    end
    idle();
    repeat (3) tick();

    // 2: idle load of latency 0, then combinational pass-through
    load(0, 0);
    tick();
    cfg_load = '0;
    check("t2 lat_cur", 32'(lat_cur[0 +: LW]), 32'd0);
    check("t2 no pend", 32'(cfg_pend[0]), 32'd0);
    send(0, 4'hA, 0);
    #1;
    check("t2 comb data", 32'(out_data[0 +: DW]), 32'hA);
    check("t2 comb valid", 32'(out_valid[0]), 32'd1);
    tick();
    idle();
    tick();

    // 3: 8-beat stream at latency 2, reload to 4 mid-stream
    load(0, 2);
    tick();
    cfg_load = '0;
    check("t3 lat 2", 32'(lat_cur[0 +: LW]), 32'd2);
    for (int i = 0; i < 8; i++) begin
      send(0, DW'(i + 1), 2);
      if (i == 3) load(0, 4);
      tick();
      cfg_load = '0;
      if (i == 3) check("t3 pend rises", 32'(cfg_pend[0]), 32'd1);
      if (i == 7) check("t3 pend held", 32'(cfg_pend[0]), 32'd1);
    end
    idle();
    check("t3 lat held", 32'(lat_cur[0 +: LW]), 32'd2);
    k = 0;
    while (cfg_pend[0] && k < 20) begin
      tick();
      k++;
    end
    check("t3 pend drop", 32'(cfg_pend[0]), 32'd0);
    check("t3 drain cycles", k, 32'd3);
    check("t3 lat after drain", 32'(lat_cur[0 +: LW]), 32'd4);
    send(0, 4'h9, 4);
    tick();
    idle();
    repeat (6) tick();

    // 4: over-range request clamps and sets sticky error
    load(0, 7);
    tick();
    cfg_load = '0;
    check("t4 clamped lat", 32'(lat_cur[0 +: LW]), ML);
    check("t4 cfg_err", 32'(cfg_err), 32'b001);
    load(0, 3);
    tick();
    cfg_load = '0;
    check("t4 valid reload", 32'(lat_cur[0 +: LW]), 32'd3);
    check("t4 err sticky", 32'(cfg_err[0]), 32'd1);

    // 5: simultaneous loads 0/2/5, same beat on all channels
    load(0, 0);
    load(1, 2);
    load(2, 5);
    tick();
    cfg_load = '0;
    check("t5 lat ch0", 32'(lat_cur[0*LW +: LW]), 32'd0);
    check("t5 lat ch1", 32'(lat_cur[1*LW +: LW]), 32'd2);
    check("t5 lat ch2", 32'(lat_cur[2*LW +: LW]), 32'd5);
    send(0, 4'hC, 0);
    send(1, 4'hC, 2);
    send(2, 4'hC, 5);
    tick();
    idle();
    repeat (7) tick();

    // 6: reset while a reload is pending and beats are in flight
    load(0, 2);
    tick();
    cfg_load = '0;
    check("t6 lat 2", 32'(lat_cur[0 +: LW]), 32'd2);
    send(0, 4'h5, 2);
    tick();
    send(0, 4'h6, 2);
    load(0, 1);
    tick();
    idle();
    check("t6 pend before rst", 32'(cfg_pend[0]), 32'd1);
    check("t6 beat at tap", 32'(out_valid[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("t6 rst out_valid", 32'(out_valid), 32'd0);
    check("t6 rst cfg_pend", 32'(cfg_pend), 32'd0);
    check("t6 rst cfg_err", 32'(cfg_err), 32'd0);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("t6 rst lat_cur ch%0d", c), 32'(lat_cur[c*LW +: LW]), RL);
      exp_q[c].delete();
    end
    tick();
    rst = 1'b0;
    tick();
    check("t6 pend after release", 32'(cfg_pend), 32'd0);
    check("t6 quiet after release", 32'(out_valid), 32'd0);

    // Gapped beats 0x3, gap (data 0xF), 0x4 at latency 1
    send(0, 4'h3, 1);
    tick();
    idle();
    in_data[0 +: DW] = 4'hF;
    tick();
    check("gap out_valid", 32'(out_valid[0]), 32'd0);
`ifdef QSPI_LAT_HOLD_EN
    check("gap out_data held", 32'(out_data[0 +: DW]), 32'h3);
`else
    check("gap out_data raw", 32'(out_data[0 +: DW]), 32'hF);
`endif
    send(0, 4'h4, 1);
    tick();
    idle();
    repeat (3) tick();

    for (int c = 0; c < NC; c++) check($sformatf("ch%0d queue drained", c),
                                       exp_q[c].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
